// File: rtl/bw_edge_interpolator.sv
// Linear interpolation of the threshold-crossing frequency between two bracketing bins.
// One quotient bit per cycle from a restoring divider, so the latency is fixed and independent of the data.
module bw_edge_interpolator #(
  parameter int ACCUM_WIDTH    = 18,
  parameter int FREQ_BIN_WIDTH = 16,
  parameter int FRAC_BITS      = 8,
  parameter int THRESHOLD_DB   = -7680
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   valid_i,
  input  logic [FREQ_BIN_WIDTH-1:0]              f1_i,
  input  logic [FREQ_BIN_WIDTH-1:0]              f2_i,
  input  logic signed [ACCUM_WIDTH-1:0]          L1_i,
  input  logic signed [ACCUM_WIDTH-1:0]          L2_i,
  output logic [FREQ_BIN_WIDTH+FRAC_BITS-1:0]    f_edge_o,
  output logic                                   valid_o,
  output logic                                   busy_o,
  output logic                                   degenerate_o,
  output logic                                   overrun_o
);

  localparam int AW = ACCUM_WIDTH;
  localparam int FW = FREQ_BIN_WIDTH;
  localparam int QW = FREQ_BIN_WIDTH + FRAC_BITS;
  localparam int DW = AW + 1 + QW;
  localparam int CW = $clog2(QW);
  localparam logic signed [AW:0] T_EXT = (AW+1)'(THRESHOLD_DB);

  typedef enum logic [1:0] {IDLE, SETUP, DIVIDE, DONE} state_t;

  state_t state, state_nxt;

  logic [FW-1:0]        f1_r, f2_r;
  logic signed [AW-1:0] l1_r, l2_r;
  logic                 clamp_lo, clamp_hi, degen_r;
  logic [DW-1:0]        rem, dsh;
  logic [QW-1:0]        quo;
  logic [CW-1:0]        cnt;

  logic signed [AW:0]   num, den;
  logic [AW:0]          num_mag, den_mag;
  logic [FW-1:0]        df;
  logic [AW+FW:0]       prod;
  logic [QW-1:0]        addend;

  assign num     = T_EXT - $signed({l1_r[AW-1], l1_r});
  assign den     = $signed({l2_r[AW-1], l2_r}) - $signed({l1_r[AW-1], l1_r});
  assign num_mag = num;
  assign den_mag = den;
  assign df      = f2_r - f1_r;
  assign prod    = {{FW{1'b0}}, num_mag} * {{(AW+1){1'b0}}, df};
  assign addend  = clamp_lo ? '0 : (clamp_hi ? {df, {FRAC_BITS{1'b0}}} : quo);
  assign busy_o  = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_i) state_nxt = SETUP;
      SETUP:   state_nxt = DIVIDE;
      DIVIDE:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      f1_r         <= '0;
      f2_r         <= '0;
      l1_r         <= '0;
      l2_r         <= '0;
      clamp_lo     <= 1'b0;
      clamp_hi     <= 1'b0;
      degen_r      <= 1'b0;
      rem          <= '0;
      dsh          <= '0;
      quo          <= '0;
      cnt          <= '0;
      f_edge_o     <= '0;
      valid_o      <= 1'b0;
      degenerate_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      valid_o   <= 1'b0;
      overrun_o <= valid_i && (state != IDLE);
      case (state)
        IDLE: if (valid_i) begin
          f1_r <= f1_i;
          f2_r <= f2_i;
          l1_r <= L1_i;
          l2_r <= L2_i;
        end
        SETUP: begin
          // Degenerate brackets pin the edge to f1; an overshoot pins it to f2.
          if (den[AW] || den == '0 || num[AW] || f2_r < f1_r) begin
            clamp_lo <= 1'b1;
            clamp_hi <= 1'b0;
            degen_r  <= 1'b1;
          end else if (num >= den) begin
            clamp_lo <= 1'b0;
            clamp_hi <= 1'b1;
            degen_r  <= (num != den);
          end else begin
            clamp_lo <= 1'b0;
            clamp_hi <= 1'b0;
            degen_r  <= 1'b0;
          end
          rem <= {prod, {FRAC_BITS{1'b0}}};
          dsh <= {1'b0, den_mag, {(QW-1){1'b0}}};
          quo <= '0;
          cnt <= CW'(QW-1);
        end
        DIVIDE: begin
          // Quotient is known to fit QW bits, so the divisor starts aligned at bit QW-1.
          if (rem >= dsh) begin
            rem <= rem - dsh;
            quo <= {quo[QW-2:0], 1'b1};
          end else begin
            quo <= {quo[QW-2:0], 1'b0};
          end
          dsh <= dsh >> 1;
          cnt <= cnt - 1'b1;
        end
        DONE: begin
          f_edge_o     <= {f1_r, {FRAC_BITS{1'b0}}} + addend;
          degenerate_o <= degen_r;
          valid_o      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bw_edge_interpolator.sv
// Scoreboard bench for bw_edge_interpolator: expected results are queued at acceptance
// and compared, with latency, when valid_o pulses.
module tb_bw_edge_interpolator;

  localparam int T   = -7680;
  localparam int LAT = 26;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst = 1'b1;
  logic               valid_in = 1'b0;
  logic [15:0]        f1 = '0, f2 = '0;
  logic signed [17:0] l1 = '0, l2 = '0;
  logic [23:0]        f_edge;
  logic               valid_out, busy, degen, overrun;

  bw_edge_interpolator #(
    .ACCUM_WIDTH(18), .FREQ_BIN_WIDTH(16), .FRAC_BITS(8), .THRESHOLD_DB(T)
  ) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_in),
    .f1_i(f1), .f2_i(f2), .L1_i(l1), .L2_i(l2),
    .f_edge_o(f_edge), .valid_o(valid_out), .busy_o(busy),
    .degenerate_o(degen), .overrun_o(overrun)
  );

  typedef struct {
    logic [23:0] f;
    logic        d;
    int          c;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0, n_pass = 0;
  int cyc = 0, n_valid = 0, n_overrun = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_checks++;
    if (obs === expd) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expd, cyc);
  endtask

  // Reference: direct integer evaluation of the interpolation formula and clamp rules.
  function automatic logic [24:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic signed [17:0] c, input logic signed [17:0] d);
    longint num, den, df, fe;
    logic dg;
    num = longint'(T) - longint'(c);
    den = longint'(d) - longint'(c);
    df  = longint'(b) - longint'(a);
    if (den <= 0 || num < 0 || df < 0) begin
      fe = longint'(a) * 256; dg = 1'b1;
    end else if (num > den) begin
      fe = longint'(b) * 256; dg = 1'b1;
    end else if (num == den) begin
      fe = longint'(b) * 256; dg = 1'b0;
    end else begin
      fe = longint'(a) * 256 + (num * df * 256) / den; dg = 1'b0;
    end
    return {dg, 24'(fe)};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (overrun) n_overrun++;
    if (valid_out) begin
      n_valid++;
      check("busy_at_valid", busy, 0);
      if (sb.size() == 0) check("spurious_valid", 1, 0);
      else begin
        e = sb.pop_front();
        check("f_edge", f_edge, e.f);
        check("degen", degen, e.d);
        check("latency", cyc - e.c, LAT);
      end
    end
  end

  // Call while positioned at a negedge; returns one negedge later with valid_i cleared.
  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic signed [17:0] c, input logic signed [17:0] d, input bit accept);
    exp_t e;
    logic [24:0] m;
    f1 = a; f2 = b; l1 = c; l2 = d; valid_in = 1'b1;
    if (accept) begin
      m = model(a, b, c, d);
      e.f = m[23:0]; e.d = m[24]; e.c = cyc + 1;
      sb.push_back(e);
    end
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_out) break;
    end
    check("valid_timeout", valid_out, 1);
  endtask

  initial begin
    int nv;
    logic [15:0] ra, rb;
    logic signed [17:0] rc, rd;

    repeat (3) @(negedge clk);
    check("rst_f_edge", f_edge, 0);
    check("rst_valid", valid_out, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_degen", degen, 0);

    // Directed cases, each issued back-to-back on the valid_o cycle of the previous one
    drive(16'h0100, 16'h0101, -18'sd8192, -18'sd7168, 1);
    wait_valid();
    drive(16'h0010, 16'h0020, -18'sd8704, -18'sd7168, 1);
    wait_valid();
    drive(16'h0100, 16'h0101, -18'sd8000, -18'sd7680, 1);
    wait_valid();
    drive(16'h0040, 16'h0041, -18'sd7680, -18'sd7680, 1);
    wait_valid();
    drive(16'h0040, 16'h0041, -18'sd7000, -18'sd7680, 1);
    wait_valid();
    check("clamp_value", f_edge, 24'h004000);
    repeat (3) @(negedge clk);

    // Overrun while busy, with busy profile
    nv = n_valid;
    check("busy_before", busy, 0);
    drive(16'h0100, 16'h0101, -18'sd8192, -18'sd7168, 1);
    check("busy_setup", busy, 1);
    repeat (4) @(negedge clk);
    drive(16'h0010, 16'h0020, -18'sd8704, -18'sd7168, 0);
    check("overrun_pulse", overrun, 1);
    @(negedge clk);
    check("overrun_clear", overrun, 0);
    check("busy_divide", busy, 1);
    wait_valid();
    check("overrun_result", f_edge, 24'h010080);
    repeat (30) @(negedge clk);
    check("single_valid", n_valid - nv, 1);

    // Reset during DIVIDE
    drive(16'h0010, 16'h0020, -18'sd8704, -18'sd7168, 1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", valid_out, 0);
    check("abort_f_edge", f_edge, 0);
    check("abort_degen", degen, 0);
    check("abort_overrun", overrun, 0);
    sb.delete();
    nv = n_valid;
    repeat (40) @(negedge clk);
    check("abort_no_valid", n_valid - nv, 0);
    drive(16'h0100, 16'h0101, -18'sd8000, -18'sd7680, 1);
    wait_valid();

    // Randomised back-to-back traffic
    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom_range(16'h0100, 16'hFE00));
      rb = ra + 16'($urandom_range(0, 300));
      rc = 18'(-20000 + int'($urandom_range(0, 12319)));
      rd = 18'(-7680 + int'($urandom_range(0, 7000)));
      if (i % 4 == 3) begin
        rc = 18'(int'($urandom_range(0, 40000)) - 20000);
        rd = 18'(int'($urandom_range(0, 40000)) - 20000);
      end
      if (i % 5 == 4) rb = ra - 16'd3;
      drive(ra, rb, rc, rd, 1);
      wait_valid();
    end
    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    check("overrun_count", n_overrun, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
